eightbit_mem_responder: RTL and testbench
=========================================

// Module: eightbit_mem_responder
// PURPOSE
//  Memory-side responder for the eightbit core bus (addr/data_in/data_out/we).
//  Holds a 256-byte RAM, boots it from a byte-stream loader while holding the
//  core in reset, then serves core reads and writes. A store to OUT_ADDR is
//  also pushed into an output FIFO that drains over a valid/ready stream.
// PARAMETERS
//  OUT_ADDR    8'hE0  core-bus address of the output port (RAM-backed plus FIFO push)
//  STAT_ADDR   8'hE1  core-bus address of the read-only status byte
//  FIFO_DEPTH  4      output FIFO entries; power of two, >= 2
//  FIFO_AW     2      log2(FIFO_DEPTH)
// PORTS
//  clk          in   1  single clock; all state updates on the rising edge
//  rst          in   1  synchronous, active-high reset
//  core_rst     out  1  reset to the core; high until loading completes
//  addr         in   8  core bus address
//  wr_data      in   8  core store data (the core's data_out)
//  we           in   1  core write enable
//  rd_data      out  8  registered read data to the core (the core's data_in)
//  load_valid   in   1  loader byte valid
//  load_data    in   8  loader byte
//  load_last    in   1  qualifies load_valid; marks the final program byte
//  load_ready   out  1  high in LOAD state only
//  out_valid    out  1  FIFO not empty
//  out_data     out  8  FIFO head byte
//  out_ready    in   1  sink accepts head byte when out_valid & out_ready
//  out_overflow out  1  sticky; a push was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=LOAD, load_ptr=0, core_rst=1, rd_data=0,
//   FIFO emptied, out_overflow=0. RAM contents are not cleared.
//  LOAD: load_ready=1. A beat (load_valid & load_ready) writes mem[load_ptr]
//   and increments load_ptr. A beat with load_last=1, or a beat at
//   load_ptr=8'hFF, moves state to RUN. core_rst is registered; it goes 0
//   on the edge after the final beat. In LOAD, we is ignored, rd_data holds 0,
//   and there are no FIFO pushes.
//  RUN: load_ready=0 and load_valid is ignored. Only rst returns to LOAD.
//  Read: every RUN edge, rd_data <= (addr==STAT_ADDR) ? status : mem[addr].
//   Latency is 1 cycle. On a write cycle, rd_data returns the old contents
//   (read-before-write).
//  status = {6'b0, out_overflow, fifo_full}.
//  Write: we=1 in RUN writes mem[addr] <= wr_data at the edge. Writes to
//   STAT_ADDR do not update status; the RAM byte is written but is shadowed
//   on reads.
//  Push: we=1 & addr==OUT_ADDR in RUN pushes wr_data into the FIFO.
//   A push is accepted if the FIFO is not full, or if it is full and a pop
//   happens on the same edge. A push that is not accepted is dropped and sets
//   out_overflow.
//  Pop: occurs on out_valid & out_ready. Pop from empty is impossible because
//   out_valid=0.
//  Push and pop on the same edge: the count is unchanged and head/tail pointers
//   advance. Pointers wrap modulo FIFO_DEPTH. Occupancy uses a FIFO_AW+1 bit
//   count.
//  out_data is the head entry. It is stable while out_valid=1 and there is no pop.
//  out_overflow clears only on rst.
//  rst mid-load or mid-run: same as reset above. load_ptr restarts at 0 and
//   undrained FIFO bytes are lost.
// TESTING
//  1 Load 18 bytes, load_last on the 18th -> mem[0..17] match; load_ready=0
//    after beat 18; core_rst falls on the next edge; stalled load_valid gaps
//    do not advance load_ptr.
//  2 Load 256 bytes with load_last=0 -> RUN after the beat at ptr FF;
//    mem[FF]=last byte; extra load_valid is ignored.
//  3 RUN: addr=0x05 with mem[5]=0x51 -> rd_data=0x51 one edge later. Write
//    0x77 to 0x05 -> same-cycle read returns 0x51, next read returns 0x77.
//  4 out_ready=0, store 0x01..0x05 to 0xE0 -> FIFO holds 01..04; 5th push is
//    dropped; out_overflow=1; read 0xE1 -> 0x03; mem[E0]=0x05.
//  5 FIFO full with out_ready=1 and a store of 0x09 on the same edge -> 0x01
//    popped, 0x09 accepted, count stays 4, no overflow; the drain order is
//    02 03 04 09.
//  6 rst pulse after 3 load beats or with FIFO non-empty -> core_rst=1,
//    load_ready=1, out_valid=0, out_overflow=0; reload rewrites from address 0.

Source files
------------

// File: rtl/eightbit_mem_responder_if.sv
// Core-bus, loader and output-stream signals between the eightbit core side and the memory responder.
interface eightbit_mem_responder_if;
    logic       core_rst;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic       we;
    logic [7:0] rd_data;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       out_overflow;

    modport master (
        input  core_rst, rd_data, load_ready, out_valid, out_data, out_overflow,
        output addr, wr_data, we, load_valid, load_data, load_last, out_ready
    );

    modport slave (
        output core_rst, rd_data, load_ready, out_valid, out_data, out_overflow,
        input  addr, wr_data, we, load_valid, load_data, load_last, out_ready
    );
endinterface

// File: rtl/eightbit_mem_responder.sv
// 256-byte RAM responder for the eightbit core: boots from a byte loader while holding
// the core in reset, then serves reads/writes and streams stores to OUT_ADDR through a FIFO.
module eightbit_mem_responder #(
    parameter logic [7:0]  OUT_ADDR   = 8'hE0,
    parameter logic [7:0]  STAT_ADDR  = 8'hE1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    eightbit_mem_responder_if.slave   bus
);

    localparam int unsigned DW        = 8;
    localparam int unsigned AW        = 8;
    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned CW        = FIFO_AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       load_ptr_q, load_ptr_d;
    logic                core_rst_q;
    logic                load_ready_q;
    logic [DW-1:0]       rd_data_q, rd_data_d;
    logic [FIFO_AW-1:0]  head_q, head_d;
    logic [FIFO_AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                out_valid_q;
    logic                overflow_q, overflow_d;

    logic [DW-1:0]       mem_q  [MEM_WORDS];
    logic [DW-1:0]       fifo_q [FIFO_DEPTH];

    logic                run;
    logic                load_beat;
    logic                fifo_full;
    logic [DW-1:0]       status;
    logic                pop;
    logic                push_req;
    logic                push;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [DW-1:0]       mem_wdata;

    // Next-state decode for loader, read path, RAM write port and output FIFO.
    always_comb begin
        run        = (state_q == ST_RUN);
        load_beat  = !run && bus.load_valid;
        fifo_full  = (count_q == FULL_CNT);
        status     = {6'b0, overflow_q, fifo_full};
        pop        = out_valid_q && bus.out_ready;
        push_req   = run && bus.we && (bus.addr == OUT_ADDR);
        push       = !rst && push_req && (!fifo_full || pop);

        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        if (load_beat) begin
            load_ptr_d = load_ptr_q + 8'd1;
            if (bus.load_last || (load_ptr_q == 8'hFF)) begin
                state_d = ST_RUN;
            end
        end

        rd_data_d = '0;
        if (run) begin
            rd_data_d = (bus.addr == STAT_ADDR) ? status : mem_q[bus.addr];
        end

        mem_we    = !rst && (load_beat || (run && bus.we));
        mem_waddr = run ? bus.addr    : load_ptr_q;
        mem_wdata = run ? bus.wr_data : bus.load_data;

        head_d = pop  ? head_q + FIFO_AW'(1) : head_q;
        tail_d = push ? tail_q + FIFO_AW'(1) : tail_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q || (push_req && !push);
    end

    // Control state; core_rst trails the LOAD->RUN transition by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            load_ptr_q   <= '0;
            core_rst_q   <= 1'b1;
            load_ready_q <= 1'b1;
            rd_data_q    <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            core_rst_q   <= (state_q == ST_LOAD);
            load_ready_q <= (state_d == ST_LOAD);
            rd_data_q    <= rd_data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            out_valid_q  <= (count_d != '0);
            overflow_q   <= overflow_d;
        end
    end

    // Storage arrays carry no reset; RAM contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        if (push) begin
            fifo_q[tail_q] <= bus.wr_data;
        end
    end

    assign bus.core_rst     = core_rst_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.load_ready   = load_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = fifo_q[head_q];
    assign bus.out_overflow = overflow_q;

endmodule

// File: tb/tb_eightbit_mem_responder.sv
// Randomized scoreboard bench for eightbit_mem_responder against a queue/array reference model.
module tb_eightbit_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eightbit_mem_responder_if bus ();

    eightbit_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_mem [256];
    bit         m_run;
    int         m_ptr;
    bit         m_core_rst;
    bit         m_load_ready;
    bit         m_ovf;
    bit         m_valid = 1'b0;
    logic [7:0] m_fifo [$];
    logic [7:0] rd_exp_q [$];
    logic [7:0] out_exp_q [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Effect of one clock edge given the inputs applied during that cycle.
    task automatic model_edge(input bit r, input logic [7:0] a, input logic [7:0] wd, input bit w,
                              input bit lv, input logic [7:0] ld, input bit ll, input bit ordy);
        logic [7:0] rd;
        bit pop;
        bit full;
        rd = 8'h00;
        if (r) begin
            m_run = 1'b0;
            m_ptr = 0;
            m_core_rst = 1'b1;
            m_ovf = 1'b0;
            m_fifo.delete();
            out_exp_q.delete();
        end else begin
            m_core_rst = !m_run;
            pop  = (m_fifo.size() != 0) && ordy;
            full = (m_fifo.size() == 4);
            if (!m_run) begin
                if (pop) void'(m_fifo.pop_front());
                if (lv) begin
                    m_mem[m_ptr] = ld;
                    if (ll || m_ptr == 255) m_run = 1'b1;
                    m_ptr = (m_ptr + 1) % 256;
                end
            end else begin
                rd = (a == 8'hE1) ? {6'b0, m_ovf, full} : m_mem[a];
                if (pop) void'(m_fifo.pop_front());
                if (w && a == 8'hE0) begin
                    if (!full || pop) begin
                        m_fifo.push_back(wd);
                        out_exp_q.push_back(wd);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (w) m_mem[a] = wd;
            end
        end
        m_load_ready = !m_run;
        rd_exp_q.push_back(rd);
        m_valid = 1'b1;
    endtask

    task automatic drive(input bit r, input logic [7:0] a, input logic [7:0] wd, input bit w,
                         input bit lv, input logic [7:0] ld, input bit ll, input bit ordy);
        rst            = r;
        bus.addr       = a;
        bus.wr_data    = wd;
        bus.we         = w;
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.load_last  = ll;
        bus.out_ready  = ordy;
        @(posedge clk);
        model_edge(r, a, wd, w, lv, ld, ll, ordy);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
    endtask

    task automatic load_beat(input logic [7:0] d, input bit last);
        drive(1'b0, 8'hE0, 8'($urandom), 1'($urandom), 1'b1, d, last, 1'($urandom));
    endtask

    task automatic load_stall();
        drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic run_cyc(input logic [7:0] a, input logic [7:0] wd, input bit w, input bit ordy);
        drive(1'b0, a, wd, w, 1'($urandom), 8'($urandom), 1'($urandom), ordy);
    endtask

    task automatic load_prog(input int nbytes, input bit use_last);
        int i;
        i = 0;
        while (i < nbytes) begin
            if ($urandom_range(0, 3) == 0) begin
                load_stall();
            end else begin
                load_beat(8'($urandom), use_last && (i == nbytes - 1));
                i++;
            end
        end
    endtask

    // Monitor: compares DUT outputs against model expectations between clock edges.
    always @(negedge clk) begin
        if (m_valid) begin
            if (rd_exp_q.size() != 0) chk("rd_data", bus.rd_data, rd_exp_q.pop_front());
            chk("core_rst",     {7'b0, bus.core_rst},     {7'b0, m_core_rst});
            chk("load_ready",   {7'b0, bus.load_ready},   {7'b0, m_load_ready});
            chk("out_overflow", {7'b0, bus.out_overflow}, {7'b0, m_ovf});
            chk("out_valid",    {7'b0, bus.out_valid},    {7'b0, m_fifo.size() != 0});
            if (bus.out_valid && bus.out_ready) begin
                if (out_exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_data: got unexpected byte %h expected none", bus.out_data);
                end else begin
                    chk("out_data", bus.out_data, out_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.addr       = '0;
        bus.wr_data    = '0;
        bus.we         = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.out_ready  = 1'b0;

        do_reset();
        do_reset();

        // Full 256-byte image without load_last; ends at ptr FF, then extra beats are ignored.
        load_prog(256, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) run_cyc(8'($urandom), 8'h00, 1'b0, 1'b0);

        // Reset after three beats, then an 18-byte program from address 0.
        do_reset();
        for (int k = 0; k < 3; k++) load_beat(8'($urandom), 1'b0);
        do_reset();
        load_prog(18, 1'b1);
        for (int k = 0; k < 20; k++) run_cyc(8'(k), 8'h00, 1'b0, 1'b0);

        // Read-before-write on address 5.
        run_cyc(8'h05, 8'h51, 1'b1, 1'b0);
        run_cyc(8'h05, 8'h00, 1'b0, 1'b0);
        run_cyc(8'h05, 8'h77, 1'b1, 1'b0);
        run_cyc(8'h05, 8'h00, 1'b0, 1'b0);

        // Fill FIFO with sink stalled; fifth store overflows.
        for (int k = 1; k <= 5; k++) run_cyc(8'hE0, 8'(k), 1'b1, 1'b0);
        run_cyc(8'hE1, 8'h00, 1'b0, 1'b0);
        run_cyc(8'hE0, 8'h00, 1'b0, 1'b0);

        // Push into a full FIFO on a popping edge, then drain.
        run_cyc(8'hE0, 8'h09, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) run_cyc(8'hE1, 8'h00, 1'b0, 1'b1);

        // Random RUN traffic biased toward the output and status bytes.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] a;
            case ($urandom_range(0, 3))
                0:       a = 8'hE0;
                1:       a = 8'hE1;
                default: a = 8'($urandom);
            endcase
            run_cyc(a, 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0));
        end

        // Reset with undrained FIFO bytes, reload, and run a bit.
        run_cyc(8'hE0, 8'hA5, 1'b1, 1'b0);
        run_cyc(8'hE0, 8'h5A, 1'b1, 1'b0);
        do_reset();
        load_prog(10, 1'b1);
        for (int k = 0; k < 30; k++) run_cyc(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int k = 0; k < 8; k++) run_cyc(8'h00, 8'h00, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        chk("rd_queue_left", 8'(rd_exp_q.size()), 8'd0);
        chk("out_queue_left", 8'(out_exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
